regfile_write_arbiter: RTL

Sequencer and arbiter for the single write port (we3/wa3/wd3) of the 32×32 register file. After reset it walks x1..x31 and writes zero into each. It then shares the write port between two writeback requesters: A (ALU writeback) and B (load writeback). Sharing uses valid/ready handshakes with round-robin arbitration. It drives the register file write port directly and sits between the writeback stage and the register file.

---
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// regfile_write_arbiter: zero-fills x1..x(2^AW-1) after reset, then round-robin
// shares the register file write port between writeback requesters A and B. Rev 1.0
module regfile_write_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  output logic            init_done,
  output logic [15:0]     stall_cnt
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] FIRST_IDX = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_IDX  = {AW{1'b1}};
  localparam logic          RR_A      = 1'b0;
  localparam logic          RR_B      = 1'b1;

  state_t        state, state_next;
  logic [AW-1:0] clr_idx;
  logic          rr_last;
  logic          stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Ready is gated by the requester's own valid; on a conflict the side not
  // granted last wins.
  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state)
      CLEAR: begin
        if (clr_idx == LAST_IDX) state_next = RUN;
      end
      RUN: begin
        a_ready = a_valid && (!b_valid || (rr_last == RR_B));
        b_ready = b_valid && (!a_valid || (rr_last == RR_A));
      end
      default: state_next = CLEAR;
    endcase
  end

  assign stall     = (state == RUN) && ((a_valid && !a_ready) || (b_valid && !b_ready));
  assign init_done = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx   <= FIRST_IDX;
      rr_last   <= RR_B;
      we3       <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == CLEAR) begin
        we3     <= 1'b1;
        wa3     <= clr_idx;
        wd3     <= '0;
        clr_idx <= clr_idx + 1'b1;
      end else if (a_ready) begin
        // x0 writes still complete the handshake but never reach the array.
        we3     <= (a_addr != '0);
        wa3     <= a_addr;
        wd3     <= a_data;
        rr_last <= RR_A;
      end else if (b_ready) begin
        we3     <= (b_addr != '0);
        wa3     <= b_addr;
        wd3     <= b_data;
        rr_last <= RR_B;
      end else begin
        we3     <= 1'b0;
      end

      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
